// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the round-robin ALU arbiter.
//   ALU_DW / ALU_OPW / ALU_RW : default operand, opcode and result widths
//   ST_*                      : FSM state encodings, wrapped by state_e
//   ptr_w()                   : width of a requester index (at least 1 bit)
package alu_pkg;

  localparam int unsigned ALU_DW  = 8;
  localparam int unsigned ALU_OPW = 4;
  localparam int unsigned ALU_RW  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StIssue = ST_ISSUE,
    StResp  = ST_RESP
  } state_e;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches i_ptr, i_ptr+1, ... (mod NREQ) for the first set request bit.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this search
//   o_grant : one-hot grant (all zero when nothing is requested)
//   o_idx   : index of the granted requester (0 when nothing is requested)
//   o_any   : at least one request bit is set
module rr_pick
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_sum = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr and k are both below NREQ, so one conditional subtract is a full modulo.
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any = 1'b1;
        o_idx = w_idx;
      end
    end
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU among NREQ requesters.
// Round-robin pick in IDLE, operands registered toward the ALU, result captured
// one cycle later and returned with a one-hot strobe to the winning requester.
//   clk, rst                       : clock, asynchronous active-high reset
//   req_valid/req_ready            : per-requester request handshake
//   req_op1/req_op2/req_opcode     : packed per-requester payload
//   rsp_valid/rsp_ready            : one-hot response strobe, shared consumer ready
//   rsp_result/rsp_flagC/rsp_flagZ : captured ALU outputs
//   alu_*                          : to/from the shared ALU
//   busy, grant_id, ops_done       : status, last winner, saturating completion count
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = ALU_DW,
  parameter int unsigned OPW  = ALU_OPW,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_op1,
  input  logic [NREQ*DW-1:0]  req_op2,
  input  logic [NREQ*OPW-1:0] req_opcode,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [2*DW-1:0]     rsp_result,
  output logic                rsp_flagC,
  output logic                rsp_flagZ,
  input  logic                rsp_ready,
  output logic [DW-1:0]       alu_operand1,
  output logic [DW-1:0]       alu_operand2,
  output logic [OPW-1:0]      alu_opcode,
  input  logic [2*DW-1:0]     alu_result,
  input  logic                alu_flagC,
  input  logic                alu_flagZ,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic [CNTW-1:0]     ops_done
);

  localparam int unsigned PW = ptr_w(NREQ);

  state_e          r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_rsp_valid;
  logic [2*DW-1:0] r_rsp_result;
  logic            r_rsp_flagC;
  logic            r_rsp_flagZ;
  logic [DW-1:0]   r_op1;
  logic [DW-1:0]   r_op2;
  logic [OPW-1:0]  r_opcode;
  logic [2:0]      r_grant_id;
  logic [CNTW-1:0] r_ops_done;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_win;
  logic            w_any;
  logic [DW-1:0]   w_op1;
  logic [DW-1:0]   w_op2;
  logic [OPW-1:0]  w_opcode;
  logic [PW-1:0]   w_ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // AND-OR payload mux driven by the one-hot grant.
  always_comb begin
    w_op1    = '0;
    w_op2    = '0;
    w_opcode = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_op1    = w_op1    | req_op1[i*DW +: DW];
        w_op2    = w_op2    | req_op2[i*DW +: DW];
        w_opcode = w_opcode | req_opcode[i*OPW +: OPW];
      end
    end
  end

  // Just-served requester drops to lowest priority.
  assign w_ptr_next = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

  assign req_ready = (r_state == StIdle) ? w_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_flagC  <= 1'b0;
      r_rsp_flagZ  <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_opcode     <= '0;
      r_grant_id   <= '0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_opcode   <= w_opcode;
            r_grant_id <= 3'(w_win);
            r_ptr      <= w_ptr_next;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_rsp_result <= alu_result;
          r_rsp_flagC  <= alu_flagC;
          r_rsp_flagZ  <= alu_flagZ;
          r_rsp_valid  <= NREQ'(1) << r_grant_id;
          r_state      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= '0;
            if (r_ops_done != '1) begin
              r_ops_done <= r_ops_done + CNTW'(1);
            end
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_flagC    = r_rsp_flagC;
  assign rsp_flagZ    = r_rsp_flagZ;
  assign alu_operand1 = r_op1;
  assign alu_operand2 = r_op2;
  assign alu_opcode   = r_opcode;
  assign busy         = (r_state != StIdle);
  assign grant_id     = r_grant_id;
  assign ops_done     = r_ops_done;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 16;
  localparam int unsigned CNTW = 6;   // small counter so saturation is reachable quickly

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_op1;
  logic [NREQ*DW-1:0]  req_op2;
  logic [NREQ*OPW-1:0] req_opcode;
  logic [NREQ-1:0]     rsp_valid;
  logic [RW-1:0]       rsp_result;
  logic                rsp_flagC;
  logic                rsp_flagZ;
  logic                rsp_ready;
  logic [DW-1:0]       alu_operand1;
  logic [DW-1:0]       alu_operand2;
  logic [OPW-1:0]      alu_opcode;
  logic [RW-1:0]       alu_result;
  logic                alu_flagC;
  logic                alu_flagZ;
  logic                busy;
  logic [2:0]          grant_id;
  logic [CNTW-1:0]     ops_done;

  logic [DW-1:0]  op1_a [NREQ];
  logic [DW-1:0]  op2_a [NREQ];
  logic [OPW-1:0] opc_a [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            idx;
    logic [RW+1:0] exp;   // {Z, C, result}
  } sb_t;
  sb_t sb[$];
  int  grants[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_op1[g*DW +: DW]     = op1_a[g];
    assign req_op2[g*DW +: DW]     = op2_a[g];
    assign req_opcode[g*OPW +: OPW] = opc_a[g];
  end

  // Reference ALU: drives the DUT's ALU port and supplies expected values.
  function automatic logic [RW+1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [OPW-1:0] op);
    logic [RW-1:0] r;
    logic          c;
    c = 1'b0;
    case (op)
      4'h0: begin r = {8'h00, a} + {8'h00, b}; c = r[DW]; end
      4'h1: begin r = {8'h00, a} - {8'h00, b}; c = r[DW]; end
      4'h2: begin r = {8'h00, a} * {8'h00, b}; c = |r[RW-1:DW]; end
      4'h3: r = {8'h00, a & b};
      4'h4: r = {8'h00, a | b};
      4'h5: r = {8'h00, a ^ b};
      default: r = {8'h00, a};
    endcase
    return {(r == '0), c, r};
  endfunction

  assign {alu_flagZ, alu_flagC, alu_result} = alu_model(alu_operand1, alu_operand2, alu_opcode);

  alu_rr_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .OPW  (OPW),
    .CNTW (CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_opcode   (req_opcode),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_flagC    (rsp_flagC),
    .rsp_flagZ    (rsp_flagZ),
    .rsp_ready    (rsp_ready),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_flagC    (alu_flagC),
    .alu_flagZ    (alu_flagZ),
    .busy         (busy),
    .grant_id     (grant_id),
    .ops_done     (ops_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    #1;
    while (!req_ready[i] && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready[i]) check("timeout_ready", 32'(req_ready[i]), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) check("timeout_idle", 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 0);
    check({tag, "_flags"}, {30'd0, rsp_flagC, rsp_flagZ}, 0);
    check({tag, "_alu_ops"}, {12'd0, alu_operand1, alu_operand2, alu_opcode}, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_ops_done"}, 32'(ops_done), 0);
  endtask

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin : mon
    sb_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (req_ready != '0) begin
        check("ready_onehot", $countones(req_ready), 1);
        for (int i = 0; i < int'(NREQ); i++) begin
          if (req_ready[i]) begin
            check("ready_has_valid", 32'(req_valid[i]), 1);
            e.idx = i;
            e.exp = alu_model(op1_a[i], op2_a[i], opc_a[i]);
            sb.push_back(e);
            grants.push_back(i);
          end
        end
      end
      if (rsp_valid != '0 && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          check("sb_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.idx));
          check("sb_rsp_result", 32'(rsp_result), 32'(e.exp[RW-1:0]));
          check("sb_rsp_flagC", 32'(rsp_flagC), 32'(e.exp[RW]));
          check("sb_rsp_flagZ", 32'(rsp_flagZ), 32'(e.exp[RW+1]));
        end
      end
    end
  end

  initial begin
    logic [CNTW-1:0] ops;
    int              prev;
    int              exp_cnt;

    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin
      op1_a[i] = '0;
      op2_a[i] = '0;
      opc_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single request from requester 2
    op1_a[2] = 8'h7F; op2_a[2] = 8'h7F; opc_a[2] = 4'h2;
    req_valid = 4'b0100;
    #1;
    check("t1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("t1_alu_op1", 32'(alu_operand1), 32'h7F);
    check("t1_alu_op2", 32'(alu_operand2), 32'h7F);
    check("t1_alu_opcode", 32'(alu_opcode), 32'h2);
    check("t1_grant_id", 32'(grant_id), 2);
    check("t1_busy", 32'(busy), 1);
    check("t1_no_rsp_yet", 32'(rsp_valid), 0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h4);
    check("t1_rsp_result", 32'(rsp_result), 32'h3F01);
    check("t1_flagC", 32'(rsp_flagC), 1);
    check("t1_flagZ", 32'(rsp_flagZ), 0);
    tick();
    check("t1_ops_done", 32'(ops_done), 1);
    check("t1_idle", 32'(busy), 0);
    check("t1_rsp_clear", 32'(rsp_valid), 0);

    // Contention: all four valid from reset
    rst = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin
      op1_a[i] = DW'(8'h10 * i + 3);
      op2_a[i] = DW'(i + 1);
      opc_a[i] = OPW'(i);
    end
    req_valid = 4'hF;
    tick();
    grants.delete();
    rst = 1'b0;
    for (int n = 0; n < 100 && grants.size() < 8; n++) begin
      prev = grants.size();
      tick();
      if (grants.size() > prev) check("t2_grant_id", 32'(grant_id), 32'(grants[$]));
    end
    req_valid = '0;
    check("t2_grant_count", 32'(grants.size()), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < grants.size()) check("t2_grant_order", 32'(grants[k]), 32'(k % 4));
    end
    wait_idle();

    // Backpressure on requester 1 (pointer is back at 0)
    rsp_ready = 1'b0;
    op1_a[1] = 8'hF0; op2_a[1] = 8'h20; opc_a[1] = 4'h0;
    req_valid = 4'b0010;
    wait_ready(1);
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1000;
    for (int n = 0; n < 5; n++) begin
      check("t3_hold_valid", 32'(rsp_valid), 32'h2);
      check("t3_hold_result", 32'(rsp_result), 32'h0110);
      check("t3_hold_flagC", 32'(rsp_flagC), 1);
      check("t3_no_ready", 32'(req_ready), 0);
      tick();
    end
    ops = ops_done;
    rsp_ready = 1'b1;
    tick();
    check("t3_idle", 32'(busy), 0);
    check("t3_rsp_drop", 32'(rsp_valid), 0);
    check("t3_ops_inc", 32'(ops_done), 32'(ops + CNTW'(1)));
    check("t3_next_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("t3_ops_once", 32'(ops_done), 32'(ops + CNTW'(1)));
    wait_idle();

    // Withdrawal: requester 1 pulses while requester 0 sits in RESP
    rsp_ready = 1'b0;
    op1_a[0] = 8'h5A; op2_a[0] = 8'hA5; opc_a[0] = 4'h5;
    req_valid = 4'b0001;
    wait_ready(0);
    tick();
    req_valid = '0;
    tick();
    check("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    grants.delete();
    req_valid = 4'b0010;
    #1;
    check("t4_pulse_no_ready", 32'(req_ready), 0);
    tick();
    req_valid = 4'b1000;
    tick();
    rsp_ready = 1'b1;
    tick();
    check("t4_ready_3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("t4_grant_count", 32'(grants.size()), 1);
    if (grants.size() > 0) check("t4_grant_3", 32'(grants[0]), 3);
    wait_idle();

    // Reset during ISSUE for requester 3
    op1_a[3] = 8'h33; op2_a[3] = 8'h11; opc_a[3] = 4'h1;
    req_valid = 4'b1000;
    wait_ready(3);
    tick();
    req_valid = '0;
    check("t5_busy", 32'(busy), 1);
    check("t5_grant_id", 32'(grant_id), 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5");
    req_valid = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t5_ptr0_ready", 32'(req_ready), 32'h1);
    check("t5_ops_zero", 32'(ops_done), 0);
    tick();
    req_valid = '0;
    wait_idle();
    check("t5_ops_one", 32'(ops_done), 1);

    // Saturation of ops_done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 70; k++) begin
      op1_a[2] = DW'($urandom_range(255));
      op2_a[2] = DW'($urandom_range(255));
      opc_a[2] = OPW'($urandom_range(6));
      req_valid = 4'b0100;
      wait_ready(2);
      tick();
      req_valid = '0;
      wait_idle();
      exp_cnt = (k + 1 > 63) ? 63 : k + 1;
      check("t6_ops_done", 32'(ops_done), 32'(exp_cnt));
    end
    check("t6_saturated", 32'(ops_done), 32'h3F);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU (8-bit Operand1/Operand2, 4-bit Opcode, 16-bit Result, flagC, flagZ) among NREQ requesters.
- Round-robin arbitration, valid/ready request handshake, and registered ALU operands.
- Each accepted operation's Result/flags are captured and returned to the winning requester with a one-hot response strobe.
- Sits between requester blocks (sequencers, test drivers) and the single ALU instance.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, operand width; Result width is 2*DW
OPW, 4, opcode width
CNTW, 16, width of completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high
req_op1  in  NREQ*DW  packed Operand1, requester i at [i*DW +: DW]
req_op2  in  NREQ*DW  packed Operand2
req_opcode  in  NREQ*OPW  packed Opcode
rsp_valid  out  NREQ  one-hot response strobe, bit = owning requester
rsp_result  out  2*DW  captured ALU Result
rsp_flagC  out  1  captured flagC
rsp_flagZ  out  1  captured flagZ
rsp_ready  in  1  shared response consumer ready
alu_operand1  out  DW  to ALU Operand1
alu_operand2  out  DW  to ALU Operand2
alu_opcode  out  OPW  to ALU Opcode
alu_result  in  2*DW  from ALU Result
alu_flagC  in  1  from ALU flagC
alu_flagZ  in  1  from ALU flagZ
busy  out  1  high in any state other than IDLE
grant_id  out  3  index of current or last granted requester
ops_done  out  CNTW  saturating count of completed responses

Behaviour:
- Reset (async, rst=1): state IDLE; rr pointer=0; req_ready=0; rsp_valid=0; rsp_result=0; rsp_flagC/Z=0; alu_operand1/2=0; alu_opcode=0; busy=0; grant_id=0; ops_done=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, … mod NREQ.
  - req_ready[winner]=1, combinational from req_valid and registered ptr; all other req_ready bits are 0.
  - No valid request: stay IDLE, req_ready=0.
  - On handshake: latch winner's op1/op2/opcode into alu_operand1/alu_operand2/alu_opcode; grant_id←winner; ptr←(winner+1) mod NREQ; →ISSUE.
- ISSUE (one cycle):
  - ALU inputs are stable from registers.
  - At the cycle-end edge: rsp_result←alu_result, rsp_flagC←alu_flagC, rsp_flagZ←alu_flagZ; rsp_valid←onehot(grant_id); →RESP.
- RESP:
  - Hold rsp_valid and rsp_* stable until rsp_ready=1.
  - On rsp_ready: rsp_valid←0; ops_done←ops_done+1, saturating at all-ones; →IDLE.
  - req_ready=0 throughout RESP.
- Latency: handshake at cycle N → ISSUE N+1 → rsp_valid from N+2. Minimum 3 cycles per operation, no overlap.
- alu_operand*/alu_opcode hold their last value after an operation; they are not cleared.
- Request rule: requesters hold req_valid and payload until req_ready. A dropped req_valid is simply not granted; no error.
- Simultaneous requests: exactly one grant per IDLE cycle. The just-served requester gets lowest priority next time.
- NREQ=1: ptr stays 0; the block degenerates to a sequencer.
- rst asserted mid-ISSUE or mid-RESP: the operation is discarded, no response is issued, ops_done is unchanged from its reset value 0, and all outputs return to reset values immediately.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2;
  - ALU widths (DW=8, OPW=4, RW=16).
- One sub-module, rr_pick:
  - inputs: NREQ-bit request vector and pointer;
  - outputs: one-hot grant, winner index, any-valid;
  - purely combinational.
- The FSM, registers and counter live in the top.

Test Plan:
- Single request: req_valid[2]=1, op1=8'h7F, op2=8'h7F, opcode=4'b0010.
  - req_ready[2] high in IDLE; alu_operand1/2=8'h7F, alu_opcode=4'h2 the next cycle.
  - rsp_valid=4'b0100 two cycles after the handshake; rsp_result/flags equal the ALU model output for those inputs; ops_done=1.
- Contention: all four req_valid held high from reset.
  - Grant order 0,1,2,3,0,…; grant_id follows; no requester served twice before the others are served once.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid and rsp_result stable throughout; all req_ready=0.
  - Release rsp_ready: IDLE next cycle; ops_done increments once only.
- Withdrawal: req_valid[1] pulsed for one cycle while the block is in RESP serving requester 0.
  - No grant to requester 1; the next grant goes to any still-valid requester per the pointer.
- Reset mid-op: assert rst during ISSUE for requester 3.
  - All outputs reset immediately; rsp_valid never asserts for that operation; ptr=0 afterwards, so requester 0 wins the next contention.
- Saturation: perform 65537 back-to-back single-requester operations with rsp_ready=1.
  - ops_done reaches 16'hFFFF and stays there; rsp behaviour is unaffected.
